multi_debounce: RTL and testbench
=================================

# multi_debounce

Multi-channel parametrised push-button conditioner for the board-level input path: synchronises, polarity-normalises and debounces `N_CH` raw button pins. For each channel it outputs a stable logical level, single-cycle press/release events, a long-press event and an optional auto-repeat event. It sits between the GPIO pins and the application FSMs and replaces per-button single-channel debouncers.

## Interface
- `CLK_FREQ_HZ`, 10_000_000, system clock frequency in Hz
- `N_CH`, 4, number of button channels (1..32)
- `ACTIVE_LOW`, {N_CH{1'b0}}, per-channel polarity mask; bit=1 means the pin reads 0 when pressed (pull-up)
- `DEBOUNCE_US`, 500, required stable time in µs
- `LONG_MS`, 1000, hold time in ms before the long-press event
- `REPEAT_MS`, 0, auto-repeat period in ms after a long press; 0 disables repeat
- `clk` in 1, system clock
- `rst_n` in 1, asynchronous, active-low reset
- `btn_in` in N_CH, raw asynchronous button pins
- `btn_state` out N_CH, debounced logical level; 1 = pressed
- `press_evt` out N_CH, 1-cycle pulse on a debounced 0→1 transition
- `release_evt` out N_CH, 1-cycle pulse on a debounced 1→0 transition
- `long_evt` out N_CH, 1-cycle pulse once per hold, after LONG_CYCLES of continuous press
- `repeat_evt` out N_CH, 1-cycle pulse every REPEAT_CYCLES after long_evt while still held
- `any_evt` out 1, combinational OR of all event bits on all channels

## Operation
- Derived constants:
  - DEB_CYCLES = CLK_FREQ_HZ/1000*DEBOUNCE_US/1000
  - LONG_CYCLES = CLK_FREQ_HZ/1000*LONG_MS
  - REPEAT_CYCLES = CLK_FREQ_HZ/1000*REPEAT_MS
  - Each must be ≥ 2 when used; elaboration error otherwise (REPEAT_CYCLES exempt when REPEAT_MS=0).
- Counter widths are $clog2(constant+1). There is no wrap-around: all counters clear or saturate.
- Per channel, `btn_in[i]` passes through a 2-FF synchroniser. The logical level is sync2 ^ ACTIVE_LOW[i].
- Debounce, evaluated each edge:
  - If logical ≠ btn_state and deb_cnt == DEB_CYCLES-1: btn_state ← logical, deb_cnt ← 0, and the matching press_evt/release_evt is asserted for that one cycle.
  - If logical ≠ btn_state otherwise: deb_cnt ← deb_cnt+1.
  - If logical == btn_state: deb_cnt ← 0. Any single matching cycle restarts the debounce window.
- Hold FSM per channel, states IDLE, HELD, LONG:
  - IDLE→HELD on press_evt; hold_cnt ← 0.
  - HELD: hold_cnt increments. When hold_cnt == LONG_CYCLES-1: long_evt, →LONG, rep_cnt ← 0.
  - LONG: if REPEAT_MS ≠ 0, rep_cnt increments and at REPEAT_CYCLES-1 asserts repeat_evt and clears. If REPEAT_MS == 0, the channel stays in LONG silently.
  - Any state → IDLE on release_evt; counters clear.
- Priority: release_evt on the same edge as a long/repeat threshold wins, and no long_evt/repeat_evt is emitted.
- Channels are fully independent; simultaneous events on several channels all assert in the same cycle.

## Timing
- Reset (asynchronous, any time, including mid-debounce or mid-hold):
  - Sync FFs ← ACTIVE_LOW[i] (inactive level).
  - btn_state ← 0, all counters ← 0, FSM ← IDLE.
  - All event outputs ← 0; no event is generated on reset release while the pin is idle.
- A button held through reset release produces press_evt DEB_CYCLES+2 edges after reset deasserts.
- Latency: a clean pin change sampled at edge 1 updates btn_state and pulses the event at edge DEB_CYCLES+2.
- long_evt occurs LONG_CYCLES edges after press_evt. The first repeat_evt occurs REPEAT_CYCLES edges after long_evt, and subsequent ones every REPEAT_CYCLES.
- All outputs except any_evt are registered.

## Structure
- Shared package header `debounce_pkg.vh`:
  - ms/µs-to-cycles constant functions.
  - clog2 width helper.
  - Hold FSM state encodings: IDLE=2'd0, HELD=2'd1, LONG=2'd2.
- Sub-module `debounce_channel`: one channel containing the synchroniser, debounce counter and hold FSM. The top level instantiates it N_CH times in a generate loop and ORs the events for any_evt.

## Test plan
Bench parameters for all scenarios: CLK_FREQ_HZ=1_000_000, DEBOUNCE_US=10 (DEB=10), LONG_MS=1 (LONG=1000), REPEAT_MS=0 unless stated.
- Clean press on ch0, pin held high → btn_state[0]=1 and a one-cycle press_evt[0] at edge 12. Release → release_evt[0] at edge 12 after the pin falls. No other channel toggles.
- Bounce: ch1 toggles every 3 cycles for 50 cycles then settles high → exactly one press_evt[1], 12 edges after the last toggle. A 9-cycle glitch produces no event.
- ACTIVE_LOW=4'b0100, pin 2 idle at 1 from reset → btn_state[2]=0 and no events. Pin driven 0 → press_evt[2].
- Hold ch3 for 2500 cycles with REPEAT_MS=1 → long_evt at 1000 cycles after press_evt, repeat_evt at +1000, then release_evt and no further events.
- Release timed to coincide with the long threshold → release_evt only, long_evt stays 0.
- rst_n asserted mid-debounce (deb_cnt=5) and mid-hold → all outputs 0 immediately. After reset release with the pin still pressed → press_evt at edge 12 and any_evt high in the same cycle.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// ---------------------------------------------------------------------------
// multi_debounce_pkg
// Shared definitions for the multi-channel button conditioner:
//   - us_to_cycles / ms_to_cycles : time-to-clock-cycle conversions
//   - cnt_width                   : counter width able to hold 0..n
//   - hold_state_t                : per-channel hold FSM encoding
// ---------------------------------------------------------------------------
package multi_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } hold_state_t;

   // Divide by 1000 first so large clock rates do not overflow 32 bits.
   function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                                input int unsigned us);
      return freq_hz / 1000 * us / 1000;
   endfunction

   function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                input int unsigned ms);
      return freq_hz / 1000 * ms;
   endfunction

   // Width of a counter holding 0..n; never below 1 bit so that disabled
   // features (n = 0) still produce a legal vector.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/multi_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One button channel: 2-FF synchroniser, polarity normalisation, debounce
// counter and the IDLE/HELD/LONG hold FSM.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   btn_in        : raw asynchronous pin
//   btn_state     : debounced logical level (1 = pressed)
//   press_evt     : 1-cycle pulse on debounced 0->1
//   release_evt   : 1-cycle pulse on debounced 1->0
//   long_evt      : 1-cycle pulse after LONG_CYCLES of continuous press
//   repeat_evt    : 1-cycle pulse every REPEAT_CYCLES after long_evt
// ---------------------------------------------------------------------------
module debounce_channel
   import multi_debounce_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = 10,
   parameter int unsigned LONG_CYCLES   = 1000,
   parameter int unsigned REPEAT_CYCLES = 0,
   parameter logic        ACT_LOW       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_state,
   output logic press_evt,
   output logic release_evt,
   output logic long_evt,
   output logic repeat_evt
);

   localparam int unsigned DEB_W  = cnt_width(DEB_CYCLES);
   localparam int unsigned LONG_W = cnt_width(LONG_CYCLES);
   localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
   localparam logic [REP_W-1:0]  REP_LAST  =
      REP_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

   logic              sync1_reg, sync2_reg;
   logic              logical;
   logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
   logic              state_reg, state_next;
   logic              press_now, release_now;
   hold_state_t       hold_reg, hold_next;
   logic [LONG_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
   logic              long_now, repeat_now;
   logic              press_reg, release_reg, long_reg, repeat_reg;

   assign logical = sync2_reg ^ ACT_LOW;

   // Debounce: a change is accepted only after DEB_CYCLES consecutive
   // samples disagree with the current level; one agreeing sample restarts.
   always_comb begin
      deb_cnt_next = deb_cnt_reg;
      state_next   = state_reg;
      press_now    = 1'b0;
      release_now  = 1'b0;
      if (logical != state_reg) begin
         if (deb_cnt_reg == DEB_LAST) begin
            state_next   = logical;
            deb_cnt_next = '0;
            press_now    = logical;
            release_now  = ~logical;
         end else begin
            deb_cnt_next = deb_cnt_reg + DEB_ONE;
         end
      end else begin
         deb_cnt_next = '0;
      end
   end

   // Hold FSM reacts to the debounce decision of the same edge, so long_evt
   // lands exactly LONG_CYCLES edges after press_evt, and a release decided
   // on a threshold edge suppresses the long/repeat pulse.
   always_comb begin
      hold_next     = hold_reg;
      hold_cnt_next = hold_cnt_reg;
      rep_cnt_next  = rep_cnt_reg;
      long_now      = 1'b0;
      repeat_now    = 1'b0;
      if (release_now) begin
         hold_next     = IDLE;
         hold_cnt_next = '0;
         rep_cnt_next  = '0;
      end else begin
         case (hold_reg)
            IDLE: begin
               if (press_now) begin
                  hold_next     = HELD;
                  hold_cnt_next = '0;
               end
            end
            HELD: begin
               if (hold_cnt_reg == LONG_LAST) begin
                  long_now      = 1'b1;
                  hold_next     = LONG;
                  hold_cnt_next = '0;
                  rep_cnt_next  = '0;
               end else begin
                  hold_cnt_next = hold_cnt_reg + LONG_ONE;
               end
            end
            LONG: begin
               if (REPEAT_CYCLES != 0) begin
                  if (rep_cnt_reg == REP_LAST) begin
                     repeat_now   = 1'b1;
                     rep_cnt_next = '0;
                  end else begin
                     rep_cnt_next = rep_cnt_reg + REP_ONE;
                  end
               end
            end
            default: begin
               hold_next     = IDLE;
               hold_cnt_next = '0;
               rep_cnt_next  = '0;
            end
         endcase
      end
   end

   // Synchroniser resets to the inactive pin level so reset release on an
   // idle pin never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg   <= ACT_LOW;
         sync2_reg   <= ACT_LOW;
         deb_cnt_reg <= '0;
         state_reg   <= 1'b0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
      end else begin
         sync1_reg   <= btn_in;
         sync2_reg   <= sync1_reg;
         deb_cnt_reg <= deb_cnt_next;
         state_reg   <= state_next;
         press_reg   <= press_now;
         release_reg <= release_now;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg     <= IDLE;
         hold_cnt_reg <= '0;
         rep_cnt_reg  <= '0;
         long_reg     <= 1'b0;
         repeat_reg   <= 1'b0;
      end else begin
         hold_reg     <= hold_next;
         hold_cnt_reg <= hold_cnt_next;
         rep_cnt_reg  <= rep_cnt_next;
         long_reg     <= long_now;
         repeat_reg   <= repeat_now;
      end
   end

   assign btn_state   = state_reg;
   assign press_evt   = press_reg;
   assign release_evt = release_reg;
   assign long_evt    = long_reg;
   assign repeat_evt  = repeat_reg;

endmodule

// File: rtl/multi_debounce.sv
// ---------------------------------------------------------------------------
// multi_debounce
// N_CH-channel push-button conditioner: one debounce_channel per pin plus a
// combinational OR of every event bit.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn_in      : raw pins [N_CH]
//   btn_state   : debounced levels, 1 = pressed [N_CH]
//   press_evt, release_evt, long_evt, repeat_evt : per-channel 1-cycle pulses
//   any_evt     : OR of all event bits of all channels (combinational)
// ---------------------------------------------------------------------------
module multi_debounce
   import multi_debounce_pkg::*;
#(
   parameter int unsigned          CLK_FREQ_HZ = 10_000_000,
   parameter int unsigned          N_CH        = 4,
   parameter logic [N_CH-1:0]      ACTIVE_LOW  = '0,
   parameter int unsigned          DEBOUNCE_US = 500,
   parameter int unsigned          LONG_MS     = 1000,
   parameter int unsigned          REPEAT_MS   = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_state,
   output logic [N_CH-1:0] press_evt,
   output logic [N_CH-1:0] release_evt,
   output logic [N_CH-1:0] long_evt,
   output logic [N_CH-1:0] repeat_evt,
   output logic            any_evt
);

   localparam int unsigned DEB_CYCLES    = us_to_cycles(CLK_FREQ_HZ, DEBOUNCE_US);
   localparam int unsigned LONG_CYCLES   = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
   localparam int unsigned REPEAT_CYCLES = ms_to_cycles(CLK_FREQ_HZ, REPEAT_MS);

   generate
      if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
         $error("multi_debounce: N_CH must be within 1..32");
      end
      if (DEB_CYCLES < 2) begin : g_bad_deb
         $error("multi_debounce: debounce time shorter than 2 clock cycles");
      end
      if (LONG_CYCLES < 2) begin : g_bad_long
         $error("multi_debounce: long-press time shorter than 2 clock cycles");
      end
      if (REPEAT_MS != 0 && REPEAT_CYCLES < 2) begin : g_bad_rep
         $error("multi_debounce: repeat period shorter than 2 clock cycles");
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         debounce_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .ACT_LOW       (ACTIVE_LOW[gi])
         ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_in      (btn_in[gi]),
            .btn_state   (btn_state[gi]),
            .press_evt   (press_evt[gi]),
            .release_evt (release_evt[gi]),
            .long_evt    (long_evt[gi]),
            .repeat_evt  (repeat_evt[gi])
         );
      end
   endgenerate

   assign any_evt = |(press_evt | release_evt | long_evt | repeat_evt);

endmodule

// File: tb/tb_multi_debounce.sv
module tb_multi_debounce;

   localparam int DEB  = 10;
   localparam int LONG = 1000;
   localparam int REPB = 1000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_in = 4'b0100;
   logic [3:0] al = 4'b0100;

   always #5 clk = ~clk;

   // A: REPEAT_MS = 0, B: REPEAT_MS = 1; same pins and reset.
   logic [3:0] a_state, a_press, a_rel, a_long, a_rep;
   logic [3:0] b_state, b_press, b_rel, b_long, b_rep;
   logic       a_any, b_any;

   multi_debounce #(.CLK_FREQ_HZ(1_000_000), .N_CH(4), .ACTIVE_LOW(4'b0100),
                    .DEBOUNCE_US(10), .LONG_MS(1), .REPEAT_MS(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_state(a_state),
      .press_evt(a_press), .release_evt(a_rel), .long_evt(a_long),
      .repeat_evt(a_rep), .any_evt(a_any));

   multi_debounce #(.CLK_FREQ_HZ(1_000_000), .N_CH(4), .ACTIVE_LOW(4'b0100),
                    .DEBOUNCE_US(10), .LONG_MS(1), .REPEAT_MS(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_state(b_state),
      .press_evt(b_press), .release_evt(b_rel), .long_evt(b_long),
      .repeat_evt(b_rep), .any_evt(b_any));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a level changes once the last DEB observed samples all
   // disagree with it; hold events are pure arithmetic on time since press.
   logic [3:0] m_s1, m_s2, m_state, m_press, m_rel, m_long, m_repa, m_repb;
   int         m_hist [4][$];
   int         m_press_edge [4];
   int         cyc = 0;

   task automatic model_reset();
      m_s1 = al; m_s2 = al;
      m_state = '0; m_press = '0; m_rel = '0;
      m_long = '0; m_repa = '0; m_repb = '0;
      for (int c = 0; c < 4; c++) m_hist[c].delete();
   endtask

   task automatic model_step();
      cyc++;
      for (int c = 0; c < 4; c++) begin
         int  obs;
         bit  all_diff;
         obs = int'(m_s2[c] ^ al[c]);
         m_s2[c] = m_s1[c];
         m_s1[c] = btn_in[c];
         m_press[c] = 1'b0; m_rel[c] = 1'b0;
         m_long[c] = 1'b0; m_repa[c] = 1'b0; m_repb[c] = 1'b0;
         m_hist[c].push_back(obs);
         if (m_hist[c].size() > DEB) void'(m_hist[c].pop_front());
         if (m_hist[c].size() == DEB) begin
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++)
               if (m_hist[c][k] == int'(m_state[c])) all_diff = 1'b0;
            if (all_diff) begin
               m_state[c] = ~m_state[c];
               if (m_state[c]) begin
                  m_press[c] = 1'b1;
                  m_press_edge[c] = cyc;
               end else begin
                  m_rel[c] = 1'b1;
               end
               m_hist[c].delete();
            end
         end
         if (m_state[c] && !m_press[c]) begin
            int e;
            e = cyc - m_press_edge[c];
            m_long[c] = (e == LONG);
            m_repb[c] = (e > LONG) && ((e - LONG) % REPB == 0);
         end
      end
   endtask

   task automatic check_outputs();
      logic [20:0] got_a, exp_a, got_b, exp_b;
      exp_a = {m_state, m_press, m_rel, m_long, m_repa,
               |(m_press | m_rel | m_long | m_repa)};
      exp_b = {m_state, m_press, m_rel, m_long, m_repb,
               |(m_press | m_rel | m_long | m_repb)};
      got_a = {a_state, a_press, a_rel, a_long, a_rep, a_any};
      got_b = {b_state, b_press, b_rel, b_long, b_rep, b_any};
      n_cmp += 2;
      if (got_a !== exp_a) begin
         n_bad++;
         $display("FAIL model_a cyc=%0d got st/pr/rl/lg/rp/any=%b want %b", cyc, got_a, exp_a);
      end
      if (got_b !== exp_b) begin
         n_bad++;
         $display("FAIL model_b cyc=%0d got st/pr/rl/lg/rp/any=%b want %b", cyc, got_b, exp_b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end else begin
         $display("ok   %s = %0d", name, got);
      end
   endtask

   function automatic logic evt_a(input int kind, input int ch);
      case (kind)
         0:       return a_press[ch];
         1:       return a_rel[ch];
         2:       return a_long[ch];
         default: return a_rep[ch];
      endcase
   endfunction

   typedef struct {
      string      name;
      logic [3:0] pins;
      int         ch;
      int         kind;      // 0 press, 1 release, 2 long, 3 repeat
      int         exp_edge;  // edges until the event; 0 = must not occur
      int         wait_n;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int found, cnt, cnt2, edge_n, long_t, rep_t;

      vecs[0] = '{"ch0_press",       4'b0101, 0, 0, 12,   20};
      vecs[1] = '{"ch0_release",     4'b0100, 0, 1, 12,   20};
      vecs[2] = '{"ch2_press_lowact",4'b0000, 2, 0, 12,   20};
      vecs[3] = '{"ch2_release",     4'b0100, 2, 1, 12,   20};
      vecs[4] = '{"ch3_press",       4'b1100, 3, 0, 12,   20};
      vecs[5] = '{"ch3_long",        4'b1100, 3, 2, 1000, 1010};
      vecs[6] = '{"ch3_no_repeat",   4'b1100, 3, 3, 0,    1200};
      vecs[7] = '{"ch3_release",     4'b0100, 3, 1, 12,   20};

      model_reset();
      btn_in = 4'b0100;
      rst_n  = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b1;

      // Idle pins (ch2 pulled up) after reset: nothing may happen.
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (a_any || b_any || a_state != 4'b0000) cnt++;
      end
      expect_int("idle_after_reset_activity", cnt, 0);

      // Directed table.
      for (int v = 0; v < 8; v++) begin
         btn_in = vecs[v].pins;
         found = 0;
         for (int k = 1; k <= vecs[v].wait_n; k++) begin
            tick();
            if (evt_a(vecs[v].kind, vecs[v].ch)) begin
               found = k;
               break;
            end
         end
         expect_int(vecs[v].name, found, vecs[v].exp_edge);
      end

      // Bounce on ch1: toggle every 3 cycles, ending high.
      cnt = 0;
      for (int c = 0; c < 51; c++) begin
         if (c % 3 == 0) btn_in[1] = ~btn_in[1];
         tick();
         if (a_press[1] || a_rel[1]) cnt++;
      end
      expect_int("bounce_events_during", cnt, 0);
      edge_n = 3; cnt = 0; found = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         edge_n++;
         if (a_press[1]) begin cnt++; found = edge_n; end
      end
      expect_int("bounce_press_count", cnt, 1);
      expect_int("bounce_press_edge", found, 12);

      // 9-cycle glitch is absorbed, 10-cycle glitch is not.
      btn_in[1] = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      btn_in[1] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (a_press[1] || a_rel[1]) cnt++;
      end
      expect_int("glitch9_events", cnt, 0);
      btn_in[1] = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      btn_in[1] = 1'b1;
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (a_rel[1]) cnt++;
         if (a_press[1]) cnt2++;
      end
      expect_int("glitch10_release", cnt, 1);
      expect_int("glitch10_press", cnt2, 1);
      btn_in[1] = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      // Auto-repeat on B: hold ch3 for 2500 cycles after press.
      btn_in[3] = 1'b1;
      found = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (b_press[3]) begin found = k; break; end
      end
      expect_int("rep_press_edge", found, 12);
      long_t = 0; rep_t = 0; cnt = 0;
      for (int t = 1; t <= 2500; t++) begin
         tick();
         if (b_long[3] && long_t == 0) long_t = t;
         if (b_rep[3]) begin cnt++; if (rep_t == 0) rep_t = t; end
      end
      expect_int("rep_long_edge", long_t, 1000);
      expect_int("rep_first_edge", rep_t, 2000);
      expect_int("rep_count", cnt, 1);
      btn_in[3] = 1'b0;
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (b_rel[3]) cnt++;
         if (b_long[3] || b_rep[3]) cnt2++;
      end
      expect_int("rep_release_count", cnt, 1);
      expect_int("rep_after_release", cnt2, 0);

      // Release decided on the very edge of the long threshold.
      btn_in[0] = 1'b1;
      found = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (a_press[0]) begin found = k; break; end
      end
      expect_int("coinc_press_edge", found, 12);
      cnt = 0;
      for (int i = 0; i < LONG - 12; i++) begin
         tick();
         if (a_long[0] || b_long[0]) cnt++;
      end
      btn_in[0] = 1'b0;
      found = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (a_long[0] || b_long[0]) cnt++;
         if (a_rel[0] && found == 0) found = k;
      end
      expect_int("coinc_release_edge", found, 12);
      expect_int("coinc_long_count", cnt, 0);

      // Reset in the middle of a hold (ch3) and a debounce (ch0).
      btn_in[3] = 1'b1;
      for (int i = 0; i < 212; i++) tick();
      btn_in[0] = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      expect_int("reset_outputs_a", int'({a_state, a_press, a_rel, a_long, a_rep, a_any}), 0);
      expect_int("reset_outputs_b", int'({b_state, b_press, b_rel, b_long, b_rep, b_any}), 0);
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b1;
      found = 0; cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (a_press[0] && found == 0) begin
            found = k;
            cnt = int'(a_press[3]) + int'(a_any) + int'(b_any);
         end
      end
      expect_int("post_reset_press_edge", found, 12);
      expect_int("post_reset_ch3_press_and_any", cnt, 3);
      btn_in = 4'b0100;
      for (int i = 0; i < 20; i++) tick();

      // Random pin activity, checked cycle by cycle against the model.
      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 1) == 0)
            btn_in = 4'($urandom_range(0, 15));
         else
            btn_in[$urandom_range(0, 3)] = ~btn_in[$urandom_range(0, 3)];
         for (int i = 0; i < int'($urandom_range(1, 30)); i++) tick();
      end
      btn_in = 4'b0100;
      for (int i = 0; i < 20; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
